// File: rtl/pipeline_types_pkg.sv
// Shared pipeline register layouts, stall classes and hazard-control types
// for the five-stage core.
package pipeline_types_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regIdx_t;

  typedef struct packed {
    regIdx_t rs;
    regIdx_t rt;
  } ifid_t;

  typedef struct packed {
    logic    dMemRead;
    regIdx_t rs;
    regIdx_t rt;
  } idex_t;

  typedef struct packed {
    logic    RegWrite;
    logic    dMemRead;
    logic    dMemWrite;
    regIdx_t wsel;
  } exmem_t;

  typedef struct packed {
    logic    RegWrite;
    logic    halt;
    regIdx_t wsel;
  } memwb_t;

  // One-hot stall class; exactly one bit is high in every cycle.
  typedef enum logic [4:0] {
    noStall    = 5'b00001,
    ifidStall  = 5'b00010,
    idexStall  = 5'b00100,
    exmemStall = 5'b01000,
    allStall   = 5'b10000
  } pStall_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FW_RF    = 2'b00;
  localparam logic [1:0] FW_EXMEM = 2'b01;
  localparam logic [1:0] FW_MEMWB = 2'b10;

  // A load in EX/MEM has no data yet, so only MEM/WB can serve it.
  function automatic logic [1:0] fwSelect(
    input regIdx_t src,
    input logic    exmemRegWrite,
    input logic    exmemLoad,
    input regIdx_t exmemWsel,
    input logic    memwbRegWrite,
    input regIdx_t memwbWsel
  );
    logic [1:0] sel;
    sel = FW_RF;
    if (src != '0) begin
      if (exmemRegWrite && !exmemLoad && (exmemWsel == src))
        sel = FW_EXMEM;
      else if (memwbRegWrite && (memwbWsel == src))
        sel = FW_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_forward.sv
// EX-stage operand forwarding selects for rs (fwa) and rt (fwb).
// Purely combinational; EX/MEM has priority over MEM/WB.
module forward_unit
  import pipeline_types_pkg::*;
(
  input  regIdx_t    rs,
  input  regIdx_t    rt,
  input  logic       exmemRegWrite,
  input  logic       exmemLoad,
  input  regIdx_t    exmemWsel,
  input  logic       memwbRegWrite,
  input  regIdx_t    memwbWsel,
  output logic [1:0] fwa,
  output logic [1:0] fwb
);

  regIdx_t    srcIdx [2];
  logic [1:0] selOut [2];

  assign srcIdx[0] = rs;
  assign srcIdx[1] = rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
      assign selOut[gi] = fwSelect(srcIdx[gi], exmemRegWrite, exmemLoad,
                                   exmemWsel, memwbRegWrite, memwbWsel);
    end
  endgenerate

  assign fwa = selOut[0];
  assign fwb = selOut[1];

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stall classes, flush strobes, forwarding selects,
// data-miss / deferred-redirect / halt FSM and a saturating stall counter.
module hazard_unit
  import pipeline_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  ifid_t            ifid,
  input  idex_t            idex,
  input  exmem_t           exmem,
  input  memwb_t           memwb,
  input  logic             ex_redirect,
  output pStall_t          pstall,
  output logic             pc_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwa,
  output logic [1:0]       fwb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_state_t    stateReg, stateNext;
  logic             redirectPendReg, redirectPendNext;
  logic [CNT_W-1:0] stallCountReg;

  logic       dataMiss, loadUse, redirectEff;
  logic [1:0] fwaRaw, fwbRaw;

  assign dataMiss    = (exmem.dMemRead | exmem.dMemWrite) & ~dhit;
  assign loadUse     = idex.dMemRead & (idex.rt != '0) &
                       ((idex.rt == ifid.rs) | (idex.rt == ifid.rt));
  // The latch is only ever set while a miss holds EX, so it is clear in RUN.
  assign redirectEff = ex_redirect | redirectPendReg;

  forward_unit uForward (
    .rs            (idex.rs),
    .rt            (idex.rt),
    .exmemRegWrite (exmem.RegWrite),
    .exmemLoad     (exmem.dMemRead),
    .exmemWsel     (exmem.wsel),
    .memwbRegWrite (memwb.RegWrite),
    .memwbWsel     (memwb.wsel),
    .fwa           (fwaRaw),
    .fwb           (fwbRaw)
  );

  assign fwa = nRST ? fwaRaw : FW_RF;
  assign fwb = nRST ? fwbRaw : FW_RF;

  always_comb begin
    stateNext        = stateReg;
    redirectPendNext = redirectPendReg;
    pstall           = noStall;
    pc_en            = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    memwb_flush      = 1'b0;
    halted           = 1'b0;

    unique case (stateReg)
      RUN, DWAIT: begin
        if ((stateReg == RUN) ? dataMiss : !dhit) begin
          pstall           = exmemStall;
          pc_en            = 1'b0;
          memwb_flush      = 1'b1;
          redirectPendNext = redirectPendReg | ex_redirect;
          stateNext        = DWAIT;
        end else begin
          redirectPendNext = 1'b0;
          stateNext        = RUN;
          if (redirectEff) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loadUse) begin
            pstall     = ifidStall;
            pc_en      = 1'b0;
            idex_flush = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        // Halt reaching writeback overrides any pending miss or redirect.
        if (memwb.halt) begin
          stateNext        = HALT;
          redirectPendNext = 1'b0;
        end
      end
      HALT: begin
        pstall = allStall;
        pc_en  = 1'b0;
        halted = 1'b1;
      end
      default: begin
        stateNext        = RUN;
        redirectPendNext = 1'b0;
      end
    endcase

    if (!nRST) begin
      pstall      = noStall;
      pc_en       = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateReg        <= RUN;
      redirectPendReg <= 1'b0;
    end else begin
      stateReg        <= stateNext;
      redirectPendReg <= redirectPendNext;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stallCountReg <= '0;
    else if ((pstall != noStall) && (stallCountReg != '1))
      stallCountReg <= stallCountReg + CNT_ONE;
  end

  assign stall_cycles = stallCountReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stalls, flushes, forwarding,
// miss/redirect deferral, halt and counter saturation.
module tb_hazard_unit;
  import pipeline_types_pkg::*;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             nRST;
  logic             ihit;
  logic             dhit;
  ifid_t            ifid;
  idex_t            idex;
  exmem_t           exmem;
  memwb_t           memwb;
  logic             ex_redirect;
  pStall_t          pstall;
  logic             pc_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic [1:0]       fwa;
  logic [1:0]       fwb;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  int numChecks = 0;
  int numErrors = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .ifid         (ifid),
    .idex         (idex),
    .exmem        (exmem),
    .memwb        (memwb),
    .ex_redirect  (ex_redirect),
    .pstall       (pstall),
    .pc_en        (pc_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_flush  (memwb_flush),
    .fwa          (fwa),
    .fwb          (fwb),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input pStall_t expStall, input logic expPc,
                          input logic expIfFl, input logic expIdFl, input logic expMwFl,
                          input logic expHalt);
    $display("[%0t] %s: pstall=%b pc_en=%b ifid_fl=%b idex_fl=%b memwb_fl=%b halted=%b fwa=%b fwb=%b cnt=%0d",
             $time, tag, pstall, pc_en, ifid_flush, idex_flush, memwb_flush, halted, fwa, fwb, stall_cycles);
    checkEq({tag, ".pstall"}, 32'(pstall), 32'(expStall));
    checkEq({tag, ".pc_en"}, 32'(pc_en), 32'(expPc));
    checkEq({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(expIfFl));
    checkEq({tag, ".idex_flush"}, 32'(idex_flush), 32'(expIdFl));
    checkEq({tag, ".memwb_flush"}, 32'(memwb_flush), 32'(expMwFl));
    checkEq({tag, ".halted"}, 32'(halted), 32'(expHalt));
  endtask

  task automatic idle();
    ihit        = 1'b1;
    dhit        = 1'b0;
    ifid        = '0;
    idex        = '0;
    exmem       = '0;
    memwb       = '0;
    ex_redirect = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic doReset();
    idle();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    nextCycle();
  endtask

  initial begin
    // Reset values hold even with inputs that would otherwise stall/forward.
    nRST = 1'b0;
    idle();
    ihit = 1'b0;
    idex.rs = 5'd5;
    exmem.RegWrite = 1'b1;
    exmem.wsel = 5'd5;
    #3;
    checkCtl("reset", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("reset.fwa", 32'(fwa), 32'(FW_RF));
    checkEq("reset.cnt", 32'(stall_cycles), 32'd0);
    idle();
    @(negedge CLK);
    nRST = 1'b1;
    nextCycle();

    // Load-use: lw $2 in ID/EX, add $3,$2,$4 in IF/ID.
    idex.dMemRead = 1'b1; idex.rt = 5'd2;
    ifid.rs = 5'd2; ifid.rt = 5'd4;
    settle();
    checkCtl("loaduse.bubble", ifidStall, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    idle();
    ifid.rs = 5'd2; ifid.rt = 5'd4;
    exmem.RegWrite = 1'b1; exmem.dMemRead = 1'b1; exmem.wsel = 5'd2;
    dhit = 1'b1;
    idex.rs = 5'd2;
    settle();
    checkCtl("loaduse.memstage", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("loaduse.noExmemFwdFromLoad", 32'(fwa), 32'(FW_RF));
    nextCycle();
    idle();
    idex.rs = 5'd2; idex.rt = 5'd4;
    memwb.RegWrite = 1'b1; memwb.wsel = 5'd2;
    settle();
    checkEq("loaduse.fwa", 32'(fwa), 32'(FW_MEMWB));
    checkEq("loaduse.fwb", 32'(fwb), 32'(FW_RF));
    checkEq("loaduse.cnt", 32'(stall_cycles), 32'd1);

    // Forwarding priority and register zero.
    nextCycle();
    idle();
    exmem.RegWrite = 1'b1; exmem.wsel = 5'd5;
    memwb.RegWrite = 1'b1; memwb.wsel = 5'd5;
    idex.rs = 5'd5; idex.rt = 5'd0;
    settle();
    checkEq("fwd.exmemWins.fwa", 32'(fwa), 32'(FW_EXMEM));
    checkEq("fwd.r0.fwb", 32'(fwb), 32'(FW_RF));
    idex.rs = 5'd0; idex.rt = 5'd5;
    settle();
    checkEq("fwd.rs0.fwa", 32'(fwa), 32'(FW_RF));
    checkEq("fwd.rt.fwb", 32'(fwb), 32'(FW_EXMEM));
    exmem.RegWrite = 1'b0;
    settle();
    checkEq("fwd.memwbOnly.fwb", 32'(fwb), 32'(FW_MEMWB));
    exmem.wsel = 5'd0; exmem.RegWrite = 1'b1; memwb.wsel = 5'd0; idex.rt = 5'd0;
    settle();
    checkEq("fwd.writeR0.fwb", 32'(fwb), 32'(FW_RF));

    // Three-cycle data miss then dhit.
    doReset();
    exmem.dMemRead = 1'b1;
    settle();
    checkCtl("miss.c1", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkEq("miss.cnt0", 32'(stall_cycles), 32'd0);
    nextCycle(); settle();
    checkCtl("miss.c2", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle(); settle();
    checkCtl("miss.c3", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    dhit = 1'b1;
    settle();
    checkCtl("miss.dhit", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("miss.cnt3", 32'(stall_cycles), 32'd3);
    nextCycle();
    idle();
    settle();
    checkCtl("miss.after", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("miss.cntHold", 32'(stall_cycles), 32'd3);

    // Redirect raised mid-miss, dropped before dhit: the latch must carry it.
    doReset();
    exmem.dMemWrite = 1'b1;
    settle();
    checkCtl("defer.c1", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    ex_redirect = 1'b1;
    settle();
    checkCtl("defer.c2", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    ex_redirect = 1'b0;
    dhit = 1'b1;
    settle();
    checkCtl("defer.dhit", noStall, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    idle();
    settle();
    checkCtl("defer.cleared", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Miss and redirect in the same RUN cycle: miss wins, redirect deferred.
    exmem.dMemRead = 1'b1;
    ex_redirect = 1'b1;
    settle();
    checkCtl("simul.miss", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    ex_redirect = 1'b0;
    dhit = 1'b1;
    settle();
    checkCtl("simul.dhit", noStall, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Redirect beats !ihit and load-use; !ihit alone bubbles IF/ID.
    nextCycle();
    idle();
    ihit = 1'b0;
    ex_redirect = 1'b1;
    settle();
    checkCtl("redir.noIhit", noStall, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b0;
    settle();
    checkCtl("ifetch.wait", noStall, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ihit = 1'b1;
    idex.dMemRead = 1'b1; idex.rt = 5'd7; ifid.rt = 5'd7;
    ex_redirect = 1'b1;
    settle();
    checkCtl("redir.overLoadUse", noStall, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b0; idex.rt = 5'd0; ifid.rt = 5'd0;
    settle();
    checkCtl("loaduse.r0", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt together with a data miss: HALT overrides, counter saturates.
    doReset();
    memwb.halt = 1'b1;
    exmem.dMemRead = 1'b1;
    settle();
    checkCtl("halt.entry", exmemStall, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    ex_redirect = 1'b1;
    settle();
    checkCtl("halt.c1", allStall, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkEq("halt.cnt1", 32'(stall_cycles), 32'd1);
    for (int i = 0; i < 20; i++) nextCycle();
    settle();
    checkCtl("halt.sticky", allStall, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkEq("halt.cntSat", 32'(stall_cycles), 32'd15);
    nextCycle(); settle();
    checkEq("halt.cntSatHold", 32'(stall_cycles), 32'd15);

    // Async reset mid-HALT takes effect immediately.
    idle();
    ihit = 1'b0;
    idex.rs = 5'd5;
    exmem.RegWrite = 1'b1; exmem.wsel = 5'd5;
    #2;
    nRST = 1'b0;
    #1;
    checkCtl("halt.reset", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("halt.reset.fwa", 32'(fwa), 32'(FW_RF));
    checkEq("halt.reset.cnt", 32'(stall_cycles), 32'd0);
    #2;
    nRST = 1'b1;
    ihit = 1'b1;
    nextCycle(); settle();
    checkCtl("postreset.run", noStall, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("postreset.fwa", 32'(fwa), 32'(FW_EXMEM));

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
